// File: rtl/matmul_pkg.sv
// Shared types and constants for the matrix-multiply engine.
// Default widths, the sequencer state enum and the C-write saturation helper.
package matmul_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_ADDR_W = 16;
  localparam int DEF_ACC_W  = 40;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    MAC,
    WRITE,
    DONE
  } matmul_state_e;

  // Clamp a signed accumulator to the signed element range.
  function automatic logic [DEF_DATA_W-1:0] sat_data(input logic signed [DEF_ACC_W-1:0] acc);
    logic signed [DEF_ACC_W-1:0] max_v;
    logic signed [DEF_ACC_W-1:0] min_v;
    max_v = {{(DEF_ACC_W-DEF_DATA_W+1){1'b0}}, {(DEF_DATA_W-1){1'b1}}};
    min_v = {{(DEF_ACC_W-DEF_DATA_W+1){1'b1}}, {(DEF_DATA_W-1){1'b0}}};
    if (acc > max_v) begin
      sat_data = max_v[DEF_DATA_W-1:0];
    end else if (acc < min_v) begin
      sat_data = min_v[DEF_DATA_W-1:0];
    end else begin
      sat_data = acc[DEF_DATA_W-1:0];
    end
  endfunction

endpackage

// File: rtl/matmul_if.sv
// Memory-side bus of the matrix-multiply engine: A/B read ports and C write port.
interface matmul_if
  import matmul_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) ();

  // Handshake: a request (req) holds its address (and write data) stable until
  // the cycle where req && gnt, which is the transfer.  A read returns exactly
  // one rvalid/rdata beat at least one cycle after its gnt; an rvalid with no
  // granted, uncaptured request is ignored.
  logic              a_req_o;
  logic [ADDR_W-1:0] a_addr_o;
  logic              a_gnt_i;
  logic              a_rvalid_i;
  logic [DATA_W-1:0] a_rdata_i;

  logic              b_req_o;
  logic [ADDR_W-1:0] b_addr_o;
  logic              b_gnt_i;
  logic              b_rvalid_i;
  logic [DATA_W-1:0] b_rdata_i;

  logic              c_req_o;
  logic [ADDR_W-1:0] c_addr_o;
  logic [DATA_W-1:0] c_wdata_o;
  logic              c_gnt_i;

  modport master (
    output a_req_o, a_addr_o, b_req_o, b_addr_o, c_req_o, c_addr_o, c_wdata_o,
    input  a_gnt_i, a_rvalid_i, a_rdata_i, b_gnt_i, b_rvalid_i, b_rdata_i, c_gnt_i
  );

  modport slave (
    input  a_req_o, a_addr_o, b_req_o, b_addr_o, c_req_o, c_addr_o, c_wdata_o,
    output a_gnt_i, a_rvalid_i, a_rdata_i, b_gnt_i, b_rvalid_i, b_rdata_i, c_gnt_i
  );

endinterface

// File: rtl/matmul_mac.sv
// Signed DATA_W x DATA_W multiplier feeding an ACC_W accumulator.
// Clear has priority over enable; the accumulator wraps, it never saturates.
module matmul_mac
  import matmul_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ACC_W  = DEF_ACC_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     en,
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [DATA_W-1:0] b,
  output logic signed [ACC_W-1:0]  acc
);

  logic signed [2*DATA_W-1:0] prod;

  assign prod = a * b;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc + {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};
    end
  end

endmodule

// File: rtl/matmul_engine.sv
// Matrix-multiply sequencer: C = A x B, one MAC per fetched A/B element pair.
// Build option MATMUL_SATURATE_EN clamps C writes; otherwise C takes acc's low bits.
module matmul_engine
  import matmul_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int ACC_W  = DEF_ACC_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] a_base_i,
  input  logic [ADDR_W-1:0] b_base_i,
  input  logic [ADDR_W-1:0] c_base_i,
  input  logic [15:0]       m_i,
  input  logic [15:0]       n_i,
  input  logic [15:0]       p_i,
  output logic              end_o,
  output logic              busy_o,
  output matmul_state_e     state_dbg,
  matmul_if.master          mem
);

  matmul_state_e state_q, state_d;

  logic [15:0]              m_q, n_q, p_q;
  logic [15:0]              i_q, j_q, k_q;
  logic [ADDR_W-1:0]        b_base_q;
  logic [ADDR_W-1:0]        a_row_q;
  logic [ADDR_W-1:0]        a_addr_q, b_addr_q, c_addr_q;
  logic                     a_gnt_q, b_gnt_q;
  logic                     a_have_q, b_have_q;
  logic signed [DATA_W-1:0] a_data_q, b_data_q;
  logic signed [ACC_W-1:0]  acc;

  logic a_req, b_req, c_req;
  logic a_fire, b_fire;
  logic a_cap, b_cap;
  logic launch, zero_dim, write_done;
  logic last_i, last_j, last_k;

  assign launch     = (state_q == IDLE) && start_i;
  assign zero_dim   = (m_i == 16'd0) || (n_i == 16'd0) || (p_i == 16'd0);
  assign last_i     = (i_q == m_q - 16'd1);
  assign last_j     = (j_q == p_q - 16'd1);
  assign last_k     = (k_q == n_q - 16'd1);

  assign a_req      = (state_q == ISSUE) && !a_gnt_q;
  assign b_req      = (state_q == ISSUE) && !b_gnt_q;
  assign c_req      = (state_q == WRITE);
  assign a_fire     = a_req && mem.a_gnt_i;
  assign b_fire     = b_req && mem.b_gnt_i;
  assign write_done = c_req && mem.c_gnt_i;

  // Data may return while the other port is still waiting for its grant.
  assign a_cap = mem.a_rvalid_i && (a_gnt_q || a_fire) && !a_have_q;
  assign b_cap = mem.b_rvalid_i && (b_gnt_q || b_fire) && !b_have_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_i) state_d = zero_dim ? DONE : ISSUE;
      ISSUE:   if ((a_gnt_q || a_fire) && (b_gnt_q || b_fire)) state_d = WAIT;
      WAIT:    if ((a_have_q || a_cap) && (b_have_q || b_cap)) state_d = MAC;
      MAC:     state_d = last_k ? WRITE : ISSUE;
      WRITE:   if (mem.c_gnt_i) state_d = (last_i && last_j) ? DONE : ISSUE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Addresses advance incrementally; each A/B/C walk is row-major.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      m_q      <= '0;
      n_q      <= '0;
      p_q      <= '0;
      i_q      <= '0;
      j_q      <= '0;
      k_q      <= '0;
      b_base_q <= '0;
      a_row_q  <= '0;
      a_addr_q <= '0;
      b_addr_q <= '0;
      c_addr_q <= '0;
      a_gnt_q  <= 1'b0;
      b_gnt_q  <= 1'b0;
      a_have_q <= 1'b0;
      b_have_q <= 1'b0;
      a_data_q <= '0;
      b_data_q <= '0;
    end else begin
      if (a_fire) a_gnt_q <= 1'b1;
      if (b_fire) b_gnt_q <= 1'b1;
      if (a_cap) begin
        a_have_q <= 1'b1;
        a_data_q <= mem.a_rdata_i;
      end
      if (b_cap) begin
        b_have_q <= 1'b1;
        b_data_q <= mem.b_rdata_i;
      end
      case (state_q)
        IDLE: begin
          if (launch) begin
            m_q      <= m_i;
            n_q      <= n_i;
            p_q      <= p_i;
            i_q      <= '0;
            j_q      <= '0;
            k_q      <= '0;
            b_base_q <= b_base_i;
            a_row_q  <= a_base_i;
            a_addr_q <= a_base_i;
            b_addr_q <= b_base_i;
            c_addr_q <= c_base_i;
          end
        end
        MAC: begin
          a_gnt_q  <= 1'b0;
          b_gnt_q  <= 1'b0;
          a_have_q <= 1'b0;
          b_have_q <= 1'b0;
          if (!last_k) begin
            k_q      <= k_q + 16'd1;
            a_addr_q <= a_addr_q + ADDR_W'(1);
            b_addr_q <= b_addr_q + ADDR_W'(p_q);
          end
        end
        WRITE: begin
          if (write_done) begin
            k_q      <= '0;
            c_addr_q <= c_addr_q + ADDR_W'(1);
            if (last_j) begin
              j_q      <= '0;
              i_q      <= i_q + 16'd1;
              a_row_q  <= a_row_q + ADDR_W'(n_q);
              a_addr_q <= a_row_q + ADDR_W'(n_q);
              b_addr_q <= b_base_q;
            end else begin
              j_q      <= j_q + 16'd1;
              a_addr_q <= a_row_q;
              b_addr_q <= b_base_q + ADDR_W'(j_q) + ADDR_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  matmul_mac #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W)
  ) u_mac (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (launch || write_done),
    .en    (state_q == MAC),
    .a     (a_data_q),
    .b     (b_data_q),
    .acc   (acc)
  );

  assign mem.a_req_o  = a_req;
  assign mem.a_addr_o = a_addr_q;
  assign mem.b_req_o  = b_req;
  assign mem.b_addr_o = b_addr_q;
  assign mem.c_req_o  = c_req;
  assign mem.c_addr_o = c_addr_q;

`ifdef MATMUL_SATURATE_EN
  assign mem.c_wdata_o = sat_data(acc);
`else
  assign mem.c_wdata_o = acc[DATA_W-1:0];
`endif

  assign end_o     = (state_q == DONE);
  assign busy_o    = (state_q != IDLE) && (state_q != DONE);
  assign state_dbg = state_q;

endmodule

// File: doc/matmul_engine.md
# matmul_engine

Compute sequencer between the APB register file and the three matrix memories. On a start pulse it reads A (m×n) and B (n×p) element by element, multiply-accumulates each output, and writes C (m×p). It then returns a one-cycle end pulse to the register file. One MAC per C-element step; no caching.

## Interface
- DATA_W, 16: element width; signed two's complement.
- ADDR_W, 16: word address width, matching register-file base addresses.
- ACC_W, 40: accumulator width; must be ≥ 2·DATA_W + 8.
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- start_i  in  1  single-cycle start pulse from the register file.
- a_base_i, b_base_i, c_base_i  in  ADDR_W  matrix base word addresses.
- m_i, n_i, p_i  in  16  dimensions; captured at start.
- end_o  out  1  one-cycle completion pulse to the register file.
- busy_o  out  1  high from the cycle after start until end_o.
- a_req_o, b_req_o  out  1  read request.
- a_addr_o, b_addr_o  out  ADDR_W  read address.
- a_gnt_i, b_gnt_i  in  1  request accepted this cycle.
- a_rvalid_i, b_rvalid_i  in  1  read data valid.
- a_rdata_i, b_rdata_i  in  DATA_W  read data.
- c_req_o  out  1  write request.
- c_addr_o  out  ADDR_W  write address.
- c_wdata_o  out  DATA_W  write data.
- c_gnt_i  in  1  write accepted.

## Operation
- Row-major, word addressed:
  - A[i][k] = a_base + i·n + k
  - B[k][j] = b_base + k·p + j
  - C[i][j] = c_base + i·p + j
- Address arithmetic is modulo 2^ADDR_W; no bounds check.
- Bases and dimensions are latched on start. Register changes mid-run have no effect.
- FSM states and transitions:
  - IDLE: on start_i, go to ISSUE. If any of m, n, p is 0, go to DONE instead; no memory access is made.
  - ISSUE: assert a_req_o and b_req_o together. Each request is held, with a stable address, until its gnt. Once both are granted, go to WAIT.
  - WAIT: capture each rdata on its rvalid; the two may arrive in any order or together. When both are captured, go to MAC.
  - MAC: acc += A·B, signed, full ACC_W. If k = n−1, go to WRITE; otherwise k++ and go to ISSUE.
  - WRITE: assert c_req_o with data from acc until c_gnt_i. Then clear acc and k. Advance j; at j = p−1, set j = 0 and advance i. If i wraps past m−1, go to DONE; otherwise go to ISSUE.
  - DONE: end_o = 1 for one cycle, then IDLE.
- start_i outside IDLE is ignored.
- A gnt and rvalid in the same cycle for the same port is legal.
- rvalid without an outstanding request is ignored.

## Timing
- Reset (rst_n low at a clk edge) has these effects:
  - All outputs go to 0, state to IDLE, and counters and accumulator to 0.
  - Reset mid-run abandons the operation; no end_o is produced.
- Memory read latency ≥1 cycle after gnt, arbitrary.
- With zero-wait memories (gnt in the request cycle, rvalid the next cycle):
  - 3 cycles per MAC (ISSUE, WAIT, MAC).
  - +1 cycle per C write.
  - Total = 3·m·n·p + m·p + 2 cycles from start_i to end_o, inclusive of the DONE cycle.
- Zero-dimension run: end_o asserts 2 cycles after start_i.
- busy_o is low in IDLE and in the DONE cycle.

## Configuration
- MATMUL_SATURATE_EN defined: the written value is acc clamped to [−2^(DATA_W−1), 2^(DATA_W−1)−1].
- Not defined: the written value is acc[DATA_W−1:0] (wrap).
- The accumulator itself never saturates in either mode.

## Structure
- matmul_pkg holds:
  - the state enum (IDLE, ISSUE, WAIT, MAC, WRITE, DONE);
  - default DATA_W, ADDR_W and ACC_W constants;
  - the saturation function.
- Sub-module matmul_mac: signed DATA_W×DATA_W multiply, ACC_W accumulate, with clear and enable inputs.

## Test plan
- Identity test: m=n=p=2, A=[1,2;3,4], B=identity. C must read back [1,2;3,4] at c_base..c_base+3. end_o arrives exactly 30 cycles after start.
- Zero-dimension test: m=0, n=3, p=2. end_o must pulse 2 cycles after start, with no a_req, b_req or c_req.
- Stall test: random gnt delays of 0–5 cycles and rvalid latencies of 1–4 cycles. Addresses must stay stable while req is high. A 3×4·4×2 result must match the golden model.
- Saturation test: 1×2·2×1 with all elements 0x7FFF.
  - With MATMUL_SATURATE_EN, C must be 0x7FFF.
  - Without it, C must be 0x0002 (0x7FFE0002 truncated).
- Reset and restart test: pulse start during a run, then assert rst_n low mid-WAIT.
  - The mid-run start must not restart the operation.
  - After reset, all outputs must be 0 and end_o must not appear.
  - A fresh start must then complete correctly.
